reg_file: RTL and testbench
===========================

# reg_file

Architectural register file with ROB rename tags for the Tomasulo core. It is the receiving end of the reorder buffer's issue-time rename interface and its commit write-back. At issue it records which ROB entry will produce each destination register. At commit it writes the retired value and releases the tag. It answers two combinational operand queries per cycle for the instruction being dispatched.

## Interface
Parameters:
- REG_BIT, 5, register index width (32 architectural registers).
- ROB_BIT, 3, ROB entry index width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  pause: when low, no state changes.
- set_valid  input  1  a rename is requested this cycle.
- set_reg_id  input  REG_BIT  destination register being renamed.
- set_rob_entry  input  ROB_BIT  ROB entry that will produce it.
- commit_valid  input  1  ROB retires a register-writing instruction.
- commit_reg_id  input  REG_BIT  retired destination.
- commit_rob_entry  input  ROB_BIT  retired ROB entry.
- commit_value  input  32  retired result.
- flush  input  1  mispredict / jalr recovery; drops all pending tags.
- rs1_id, rs2_id  input  REG_BIT each  operand query indices.
- rs1_value, rs2_value  output  32 each  register value.
- rs1_busy, rs2_busy  output  1 each  value still pending in the ROB.
- rs1_rob_entry, rs2_rob_entry  output  ROB_BIT each  producing entry when busy.

## Operation
- State per register: value[31:0], busy, dep[ROB_BIT-1:0]. Register x0 is hardwired: value 0, never busy, and writes and renames to it are ignored.
- Rename: when set_valid && rdy_in && !flush, the register's busy is set to 1 and dep is set to set_rob_entry. A later rename overwrites an earlier one.
- Commit: when commit_valid && rdy_in, value[commit_reg_id] is set to commit_value. busy is cleared only if dep == commit_rob_entry and there is no same-cycle rename of the same register. A stale commit (tag mismatch) writes the value and leaves busy/dep untouched.
- Flush: all busy bits are cleared next cycle. Values are kept. A same-cycle commit still writes its value. A same-cycle rename is discarded.
- Query outputs are combinational from current state plus the bypass described under Configuration. A rename in the same cycle is NOT visible, so an instruction with rs == rd sees the prior mapping.
- When busy=0, rob_entry outputs are 0.

## Timing
- Query latency is 0 cycles. Rename, commit and flush effects are visible on the cycle after the triggering edge.
- Reset: all values 0, busy 0, dep 0. Every output reads 0 with busy 0 during and after reset.
- Priority at an edge, highest first: rst_in, then !rdy_in (hold), then flush over rename. Commit is independent of both.
- A simultaneous rename and matching commit to the same register leaves busy=1 with dep equal to the new entry. The value is still updated.
- rdy_in low while any valid is high: the inputs are dropped. The ROB holds them until rdy_in returns.

## Configuration
- REG_BYPASS_EN defined: if commit_valid && rdy_in and the queried register is busy with dep == commit_rob_entry, the query returns commit_value with busy=0 in that same cycle.
- REG_BYPASS_EN undefined: queries reflect registered state only. The consumer sees busy=1 for one extra cycle and must pick the value up from the CDB or ROB.

## Structure
- REG_BIT, ROB_BIT, ROB_SIZE and the x0 index constant belong in the shared constants include (Const.v).
- One sub-module, reg_read_port, is instantiated twice. It holds the x0 masking, the bypass compare and the output muxing for a single rs port.

## Test plan
- Reset, then query rs1=5, rs2=0: both values 0 and both busy 0.
- Rename x5 to entry 3. Next cycle query x5: busy=1, rob_entry=3. Commit x5/entry3/0xDEADBEEF. Next cycle: value 0xDEADBEEF, busy=0.
- Rename x7 to entry 2, then x7 to entry 6. Commit x7/entry2/0x11: value=0x11, busy=1, rob_entry=6.
- With REG_BYPASS_EN, x4 busy on entry 1. In the same cycle as commit x4/entry1/0x55, query x4: value 0x55, busy=0. Without the macro: busy=1 that cycle and value 0x55 with busy 0 the next cycle.
- Rename x9 to entry 4 in the same cycle as flush. Next cycle x9 busy=0. Rename x0 to entry 5 and commit x0 with 0xFF: x0 reads 0 and busy 0.
- rdy_in=0 during rename x3 to entry 7 and commit x3 with 0x22: no change. Once rdy_in returns high, the next edge applies both.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants for the architectural register file.
//   REG_BIT_DEF / ROB_BIT_DEF : default register-index and ROB-index widths
//   ROB_SIZE_DEF              : number of ROB entries at the default width
//   XLEN                      : architectural register width
//   X0_ID                     : index of the hardwired zero register
package reg_file_pkg;

  localparam int unsigned REG_BIT_DEF  = 5;
  localparam int unsigned ROB_BIT_DEF  = 3;
  localparam int unsigned ROB_SIZE_DEF = 1 << ROB_BIT_DEF;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned X0_ID        = 0;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_read_port: one combinational operand query port of reg_file.
// Applies x0 masking, the optional commit bypass and rob_entry zeroing.
// Build option: REG_BYPASS_EN forwards a matching same-cycle commit.
// Ports:
//   rst_in                          : forces all outputs to zero
//   rs_id                           : queried register index
//   reg_value / reg_busy / reg_dep  : registered state of rs_id
//   rdy_in, commit_*                : commit stream, used for the bypass
//   rs_value / rs_busy / rs_rob_entry : query result
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_BIT = REG_BIT_DEF,
  parameter int unsigned ROB_BIT = ROB_BIT_DEF
) (
  input  logic               rst_in,
  input  logic [REG_BIT-1:0] rs_id,
  input  logic [XLEN-1:0]    reg_value,
  input  logic               reg_busy,
  input  logic [ROB_BIT-1:0] reg_dep,
  input  logic               rdy_in,
  input  logic               commit_valid,
  input  logic [REG_BIT-1:0] commit_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [XLEN-1:0]    commit_value,
  output logic [XLEN-1:0]    rs_value,
  output logic               rs_busy,
  output logic [ROB_BIT-1:0] rs_rob_entry
);

`ifndef REG_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{rdy_in, commit_valid, commit_reg_id, commit_rob_entry, commit_value};
`endif

  // Output mux: registered state, optional bypass, then masking.
  always_comb begin
    rs_value     = reg_value;
    rs_busy      = reg_busy;
    rs_rob_entry = reg_dep;
`ifdef REG_BYPASS_EN
    if (commit_valid && rdy_in && reg_busy && (reg_dep == commit_rob_entry) &&
        (rs_id == commit_reg_id)) begin
      rs_value = commit_value;
      rs_busy  = 1'b0;
    end
`endif
    if (!rs_busy) begin
      rs_rob_entry = '0;
    end
    if (rst_in || (rs_id == REG_BIT'(X0_ID))) begin
      rs_value     = '0;
      rs_busy      = 1'b0;
      rs_rob_entry = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file with ROB rename tags.
// Records the producing ROB entry at issue, writes retired values at
// commit, and serves two combinational operand queries per cycle.
// Build option: REG_BYPASS_EN lets a same-cycle matching commit reach
// the query outputs (see reg_read_port).
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (pause when low)
//   set_valid / set_reg_id / set_rob_entry         : rename request
//   commit_valid / commit_reg_id / commit_rob_entry / commit_value : retire
//   flush                                          : drop all pending tags
//   rs1_id, rs2_id                                 : query indices
//   rsN_value / rsN_busy / rsN_rob_entry            : query results
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_BIT = REG_BIT_DEF,
  parameter int unsigned ROB_BIT = ROB_BIT_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               set_valid,
  input  logic [REG_BIT-1:0] set_reg_id,
  input  logic [ROB_BIT-1:0] set_rob_entry,
  input  logic               commit_valid,
  input  logic [REG_BIT-1:0] commit_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [XLEN-1:0]    commit_value,
  input  logic               flush,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic [XLEN-1:0]    rs1_value,
  output logic [XLEN-1:0]    rs2_value,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [ROB_BIT-1:0] rs1_rob_entry,
  output logic [ROB_BIT-1:0] rs2_rob_entry
);

  localparam int unsigned NUM_REGS = 1 << REG_BIT;

  logic [XLEN-1:0]    value_q [NUM_REGS];
  logic               busy_q  [NUM_REGS];
  logic [ROB_BIT-1:0] dep_q   [NUM_REGS];

  // State update; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        dep_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (commit_valid && (commit_reg_id == REG_BIT'(i))) begin
          value_q[i] <= commit_value;
        end
        // Flush beats rename; a rename beats a matching commit's release.
        if (flush) begin
          busy_q[i] <= 1'b0;
          dep_q[i]  <= '0;
        end else if (set_valid && (set_reg_id == REG_BIT'(i))) begin
          busy_q[i] <= 1'b1;
          dep_q[i]  <= set_rob_entry;
        end else if (commit_valid && (commit_reg_id == REG_BIT'(i)) &&
                     (dep_q[i] == commit_rob_entry)) begin
          busy_q[i] <= 1'b0;
          dep_q[i]  <= '0;
        end
      end
    end
  end

  reg_read_port #(.REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT)) u_rs1 (
    .rst_in           (rst_in),
    .rs_id            (rs1_id),
    .reg_value        (value_q[rs1_id]),
    .reg_busy         (busy_q[rs1_id]),
    .reg_dep          (dep_q[rs1_id]),
    .rdy_in           (rdy_in),
    .commit_valid     (commit_valid),
    .commit_reg_id    (commit_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rs_value         (rs1_value),
    .rs_busy          (rs1_busy),
    .rs_rob_entry     (rs1_rob_entry)
  );

  reg_read_port #(.REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT)) u_rs2 (
    .rst_in           (rst_in),
    .rs_id            (rs2_id),
    .reg_value        (value_q[rs2_id]),
    .reg_busy         (busy_q[rs2_id]),
    .reg_dep          (dep_q[rs2_id]),
    .rdy_in           (rdy_in),
    .commit_valid     (commit_valid),
    .commit_reg_id    (commit_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rs_value         (rs2_value),
    .rs_busy          (rs2_busy),
    .rs_rob_entry     (rs2_rob_entry)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file (either build of REG_BYPASS_EN).
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        set_valid;
  logic [4:0]  set_reg_id;
  logic [2:0]  set_rob_entry;
  logic        commit_valid;
  logic [4:0]  commit_reg_id;
  logic [2:0]  commit_rob_entry;
  logic [31:0] commit_value;
  logic        flush;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_value, rs2_value;
  logic        rs1_busy, rs2_busy;
  logic [2:0]  rs1_rob_entry, rs2_rob_entry;

  reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .set_valid(set_valid), .set_reg_id(set_reg_id), .set_rob_entry(set_rob_entry),
    .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
    .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
    .flush(flush), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       tag;
    bit          port2;
    logic [31:0] v;
    logic        b;
    logic [2:0]  e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_port(input string tag, input bit port2,
                             input logic [31:0] v, input logic b, input logic [2:0] e);
    exp_t x;
    x.tag = tag; x.port2 = port2; x.v = v; x.b = b; x.e = e;
    exp_q.push_back(x);
  endtask

  // Let the query settle, then compare every pending expectation.
  task automatic drain();
    exp_t x;
    logic [31:0] av;
    logic        ab;
    logic [2:0]  ae;
    #1;
    while (exp_q.size() > 0) begin
      x  = exp_q.pop_front();
      av = x.port2 ? rs2_value     : rs1_value;
      ab = x.port2 ? rs2_busy      : rs1_busy;
      ae = x.port2 ? rs2_rob_entry : rs1_rob_entry;
      checks++;
      assert (av === x.v) else begin
        errors++;
        $error("FAIL %s value: got %h expected %h", x.tag, av, x.v);
      end
      checks++;
      assert (ab === x.b) else begin
        errors++;
        $error("FAIL %s busy: got %b expected %b", x.tag, ab, x.b);
      end
      checks++;
      assert (ae === x.e) else begin
        errors++;
        $error("FAIL %s rob_entry: got %0d expected %0d", x.tag, ae, x.e);
      end
    end
  endtask

  task automatic idle();
    set_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; idle();
    set_reg_id = '0; set_rob_entry = '0;
    commit_reg_id = '0; commit_rob_entry = '0; commit_value = '0;
    rs1_id = 5'd5; rs2_id = 5'd0;

    // During reset
    expect_port("in_reset_rs1", 0, 32'h0, 1'b0, 3'd0);
    expect_port("in_reset_rs2", 1, 32'h0, 1'b0, 3'd0);
    drain();
    tick(); tick();
    rst_in = 1'b0;
    tick();
    expect_port("post_reset_rs1", 0, 32'h0, 1'b0, 3'd0);
    expect_port("post_reset_rs2", 1, 32'h0, 1'b0, 3'd0);
    drain();

    // Rename x5 -> 3, then matching commit
    set_valid = 1'b1; set_reg_id = 5'd5; set_rob_entry = 3'd3;
    expect_port("x5_rename_invisible", 0, 32'h0, 1'b0, 3'd0);
    drain();
    tick(); idle();
    expect_port("x5_busy", 0, 32'h0, 1'b1, 3'd3);
    drain();
    commit_valid = 1'b1; commit_reg_id = 5'd5; commit_rob_entry = 3'd3;
    commit_value = 32'hDEADBEEF;
    if (BYP) expect_port("x5_commit_cycle", 0, 32'hDEADBEEF, 1'b0, 3'd0);
    else     expect_port("x5_commit_cycle", 0, 32'h0, 1'b1, 3'd3);
    drain();
    tick(); idle();
    expect_port("x5_committed", 0, 32'hDEADBEEF, 1'b0, 3'd0);
    drain();

    // Two renames of x7, stale commit of the first
    rs1_id = 5'd7;
    set_valid = 1'b1; set_reg_id = 5'd7; set_rob_entry = 3'd2;
    tick();
    set_rob_entry = 3'd6;
    tick(); idle();
    commit_valid = 1'b1; commit_reg_id = 5'd7; commit_rob_entry = 3'd2;
    commit_value = 32'h11;
    expect_port("x7_stale_no_bypass", 0, 32'h0, 1'b1, 3'd6);
    drain();
    tick(); idle();
    expect_port("x7_stale_commit", 0, 32'h11, 1'b1, 3'd6);
    drain();

    // Bypass on x4 via rs2
    rs2_id = 5'd4;
    set_valid = 1'b1; set_reg_id = 5'd4; set_rob_entry = 3'd1;
    tick(); idle();
    commit_valid = 1'b1; commit_reg_id = 5'd4; commit_rob_entry = 3'd1;
    commit_value = 32'h55;
    if (BYP) expect_port("x4_bypass", 1, 32'h55, 1'b0, 3'd0);
    else     expect_port("x4_bypass", 1, 32'h0, 1'b1, 3'd1);
    drain();
    tick(); idle();
    expect_port("x4_after_commit", 1, 32'h55, 1'b0, 3'd0);
    drain();

    // Flush with same-cycle rename of x9
    set_valid = 1'b1; set_reg_id = 5'd9; set_rob_entry = 3'd4; flush = 1'b1;
    tick(); idle();
    rs2_id = 5'd9;
    expect_port("x9_flushed_rename", 1, 32'h0, 1'b0, 3'd0);
    expect_port("x7_flushed", 0, 32'h11, 1'b0, 3'd0);
    drain();
    rs1_id = 5'd5;
    expect_port("x5_kept_after_flush", 0, 32'hDEADBEEF, 1'b0, 3'd0);
    drain();

    // x0 ignores rename and commit
    rs1_id = 5'd0;
    set_valid = 1'b1; set_reg_id = 5'd0; set_rob_entry = 3'd5;
    commit_valid = 1'b1; commit_reg_id = 5'd0; commit_rob_entry = 3'd5;
    commit_value = 32'hFF;
    tick(); idle();
    expect_port("x0_hardwired", 0, 32'h0, 1'b0, 3'd0);
    drain();

    // Rename + matching commit in the same cycle on x10
    rs1_id = 5'd10;
    set_valid = 1'b1; set_reg_id = 5'd10; set_rob_entry = 3'd1;
    tick();
    set_rob_entry = 3'd2;
    commit_valid = 1'b1; commit_reg_id = 5'd10; commit_rob_entry = 3'd1;
    commit_value = 32'h77;
    tick(); idle();
    expect_port("x10_rename_wins", 0, 32'h77, 1'b1, 3'd2);
    drain();

    // Stall: rdy_in low holds state
    rs1_id = 5'd3;
    rdy_in = 1'b0;
    set_valid = 1'b1; set_reg_id = 5'd3; set_rob_entry = 3'd7;
    commit_valid = 1'b1; commit_reg_id = 5'd3; commit_rob_entry = 3'd7;
    commit_value = 32'h22;
    tick();
    expect_port("x3_stalled", 0, 32'h0, 1'b0, 3'd0);
    drain();
    rdy_in = 1'b1;
    tick(); idle();
    expect_port("x3_released", 0, 32'h22, 1'b1, 3'd7);
    drain();

    // Mid-run reset clears state
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    rs2_id = 5'd5;
    expect_port("x3_after_reset", 0, 32'h0, 1'b0, 3'd0);
    expect_port("x5_after_reset", 1, 32'h0, 1'b0, 3'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
